// File: rtl/genius_pkg.sv
// Shared sprite indices, sequencer state encoding and command layout for the
// sprite sequencer and its command queue.
package genius_pkg;

  localparam int FRAME_W     = 6;
  localparam int SPRITE_W    = 3;
  localparam int NUM_SPRITES = 7;
  localparam int CMD_W       = SPRITE_W + FRAME_W;

  typedef enum logic [SPRITE_W-1:0] {
    SPR_BLUE    = 3'd0,
    SPR_GREEN   = 3'd1,
    SPR_RED     = 3'd2,
    SPR_YELLOW  = 3'd3,
    SPR_LOSE    = 3'd4,
    SPR_WIN     = 3'd5,
    SPR_POWER   = 3'd6,
    SPR_INVALID = 3'd7
  } sprite_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    SHOW = 2'd2,
    GAP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [SPRITE_W-1:0] sprite;
    logic [FRAME_W-1:0]  frames;
  } cmd_t;

  // Invalid index maps to no flag at all.
  function automatic logic [NUM_SPRITES-1:0] sprite_onehot(input logic [SPRITE_W-1:0] s);
    if (s == SPR_INVALID) return '0;
    return NUM_SPRITES'(1) << s;
  endfunction

endpackage

// File: rtl/sprite_cmd_fifo.sv
// Small synchronous command FIFO with show-ahead head output and a flush
// input that empties it in one cycle (flush wins over a same-cycle push/pop).
module sprite_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o && !flush_i;
  assign pop_ok  = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sprite_sequencer.sv
// Queues sprite light commands and plays them back frame-synchronously:
// timed lights separated by all-off gap frames, plus persistent flags.
module sprite_sequencer
  import genius_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_FRAMES = 8
) (
  input  logic                   VGA_CLK,
  input  logic                   RESET,
  input  logic                   FRAME_START,
  input  logic                   CMD_VALID,
  output logic                   CMD_READY,
  input  logic [SPRITE_W-1:0]    CMD_SPRITE,
  input  logic [FRAME_W-1:0]     CMD_FRAMES,
  input  logic                   CMD_CLEAR,
  output logic [NUM_SPRITES-1:0] SPRITES_FLAGS,
  output logic                   BUSY,
  output logic                   DONE
);

  state_e                 state_q, state_d;
  cmd_t                   cur_q, cur_d;
  logic [FRAME_W-1:0]     cnt_q, cnt_d;
  logic [NUM_SPRITES-1:0] persist_q, persist_d;
  logic [NUM_SPRITES-1:0] show_q, show_d;
  logic                   done_q, done_d;

  logic                   fifo_full, fifo_empty, fifo_pop, fifo_push;
  cmd_t                   fifo_head;

  sprite_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk_i   (VGA_CLK),
    .rst_i   (RESET),
    .flush_i (CMD_CLEAR),
    .push_i  (fifo_push),
    .wdata_i ({CMD_SPRITE, CMD_FRAMES}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge VGA_CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      cur_q     <= '0;
      cnt_q     <= '0;
      persist_q <= '0;
      show_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      cnt_q     <= cnt_d;
      persist_q <= persist_d;
      show_q    <= show_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    cnt_d     = cnt_q;
    persist_d = persist_q;
    show_d    = show_q;
    done_d    = 1'b0;
    if (CMD_CLEAR) begin
      state_d   = IDLE;
      cnt_d     = '0;
      persist_d = '0;
      show_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            cur_d   = fifo_head;
            state_d = ARM;
          end
        end
        ARM: begin
          if (cur_q.sprite == SPR_INVALID) begin
            state_d = IDLE;
          end else if (FRAME_START) begin
            if (cur_q.frames == '0) begin
              persist_d = persist_q | sprite_onehot(cur_q.sprite);
              state_d   = IDLE;
            end else begin
              show_d  = sprite_onehot(cur_q.sprite);
              cnt_d   = cur_q.frames;
              state_d = SHOW;
            end
          end
        end
        SHOW: begin
          // The final decrement ends the light and starts the gap in one step.
          if (FRAME_START) begin
            if (cnt_q <= FRAME_W'(1)) begin
              show_d  = '0;
              done_d  = 1'b1;
              cnt_d   = FRAME_W'(GAP_FRAMES);
              state_d = (GAP_FRAMES == 0) ? IDLE : GAP;
            end else begin
              cnt_d = cnt_q - FRAME_W'(1);
            end
          end
        end
        GAP: begin
          if (FRAME_START) begin
            cnt_d = cnt_q - FRAME_W'(1);
            if (cnt_q <= FRAME_W'(1)) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    CMD_READY     = !fifo_full && !CMD_CLEAR;
    fifo_push     = CMD_VALID && CMD_READY;
    fifo_pop      = (state_q == IDLE) && !fifo_empty && !CMD_CLEAR;
    BUSY          = !fifo_empty || (state_q != IDLE);
    SPRITES_FLAGS = persist_q | show_q;
    DONE          = done_q;
  end

endmodule

// File: tb/tb_sprite_sequencer.sv
// Self-checking bench for sprite_sequencer: directed scenarios plus random
// command/frame traffic checked against a frame-level behavioural model.
module tb_sprite_sequencer;

  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_sprite = 3'd0;
  logic [5:0] cmd_frames = 6'd0;
  logic       cmd_clear = 1'b0;
  logic [6:0] flags;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_fail = 0;
  int done_seen = 0;

  // Behavioural model: pending commands, light/gap frame budgets, persistent mask.
  logic [8:0] m_q[$];
  logic [6:0] m_persist = '0;
  int         m_show_idx = -1;
  int         m_show_left = 0;
  int         m_gap_left = 0;
  int         m_done_exp = 0;

  sprite_sequencer #(.FIFO_DEPTH(4), .GAP_FRAMES(GAP)) dut (
    .VGA_CLK       (clk),
    .RESET         (rst),
    .FRAME_START   (frame_start),
    .CMD_VALID     (cmd_valid),
    .CMD_READY     (cmd_ready),
    .CMD_SPRITE    (cmd_sprite),
    .CMD_FRAMES    (cmd_frames),
    .CMD_CLEAR     (cmd_clear),
    .SPRITES_FLAGS (flags),
    .BUSY          (busy),
    .DONE          (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_seen++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] model_flags();
    logic [6:0] f;
    f = m_persist;
    if (m_show_idx >= 0) f[m_show_idx] = 1'b1;
    return f;
  endfunction

  function automatic bit model_has_valid();
    logic [8:0] e;
    foreach (m_q[i]) begin
      e = m_q[i];
      if (e[8:6] != 3'd7) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit model_busy();
    bit free;
    free = (m_show_left == 0) && (m_gap_left == 0);
    if (!free) return 1'b1;
    return model_has_valid();
  endfunction

  function automatic void model_clear();
    m_q.delete();
    m_persist   = '0;
    m_show_idx  = -1;
    m_show_left = 0;
    m_gap_left  = 0;
  endfunction

  // One vertical blank: advance the running light or gap, else start the next command.
  function automatic void model_frame();
    logic [8:0] e;
    if (m_show_left > 0) begin
      m_show_left--;
      if (m_show_left == 0) begin
        m_done_exp++;
        m_show_idx = -1;
        m_gap_left = GAP;
      end
    end else if (m_gap_left > 0) begin
      m_gap_left--;
    end else begin
      while (m_q.size() > 0) begin
        e = m_q[0];
        if (e[8:6] != 3'd7) break;
        void'(m_q.pop_front());
      end
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
        if (e[5:0] == 6'd0) m_persist[e[8:6]] = 1'b1;
        else begin
          m_show_idx  = int'(e[8:6]);
          m_show_left = int'(e[5:0]);
        end
      end
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_cmd(input logic [2:0] s, input logic [5:0] f, output bit accepted);
    int t;
    t = 0;
    accepted = 1'b0;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_sprite = s;
    cmd_frames = f;
    while (!cmd_ready && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (cmd_ready) begin
      accepted = 1'b1;
      m_q.push_back({s, f});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("push sprite=%0d frames=%0d accepted=%0b", s, f, accepted);
  endtask

  task automatic do_clear();
    @(negedge clk);
    cmd_clear = 1'b1;
    @(negedge clk);
    cmd_clear = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (flags !== 7'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear: flags=%b busy=%b ready=%b, required 0000000/0/1", flags, busy, cmd_ready);
    end
  endtask

  task automatic frame_pulse(input int settle, input string tag);
    idle(settle);
    n_cmp++;
    if (busy !== model_busy()) begin
      n_fail++;
      $display("FAIL %s busy: got %b required %b", tag, busy, model_busy());
    end
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    model_frame();
    #1;
    n_cmp++;
    if (flags !== model_flags() || done_seen !== m_done_exp) begin
      n_fail++;
      $display("FAIL %s frame: flags=%b done_count=%0d required flags=%b done_count=%0d",
               tag, flags, done_seen, model_flags(), m_done_exp);
    end
    $display("frame %s flags=%b done_count=%0d", tag, flags, done_seen);
  endtask

  task automatic drain(input string tag);
    int k;
    k = 0;
    while ((m_show_left > 0 || m_gap_left > 0 || model_has_valid()) && k < 100) begin
      frame_pulse(5, tag);
      k++;
    end
    n_cmp++;
    if (k >= 100) begin
      n_fail++;
      $display("FAIL %s drain: model still active after %0d frames, required idle", tag, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (flags !== 7'd0 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: flags=%b done=%b busy=%b ready=%b, required 0000000/0/0/1",
               flags, done, busy, cmd_ready);
    end
  endtask

  task automatic test_red_timed();
    bit acc;
    int d0;
    d0 = done_seen;
    push_cmd(3'd2, 6'd3, acc);
    for (int p = 1; p <= 5; p++) begin
      frame_pulse(98, "red_timed");
      n_cmp++;
      if (p < 4 && flags !== 7'b0000100) begin
        n_fail++;
        $display("FAIL red_lit pulse %0d: got %b required 0000100", p, flags);
      end else if (p >= 4 && flags !== 7'b0000000) begin
        n_fail++;
        $display("FAIL red_off pulse %0d: got %b required 0000000", p, flags);
      end
    end
    n_cmp++;
    if (done_seen - d0 !== 1) begin
      n_fail++;
      $display("FAIL red_done_count: got %0d required 1", done_seen - d0);
    end
    drain("red_drain");
  endtask

  task automatic test_fill_queue();
    bit acc;
    logic [2:0] s_tab[5];
    logic [5:0] f_tab[5];
    s_tab = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    f_tab = '{6'd1, 6'd2, 6'd1, 6'd1, 6'd2};
    for (int i = 0; i < 5; i++) begin
      push_cmd(s_tab[i], f_tab[i], acc);
      if (i == 0) idle(3);
      n_cmp++;
      if (acc !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_accept %0d: accepted=%b required 1", i, acc);
      end
    end
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_full: ready=%b busy=%b required 0/1", cmd_ready, busy);
    end
    push_cmd(3'd5, 6'd1, acc);
    n_cmp++;
    if (acc !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_overflow: accepted=%b required 0", acc);
    end
    drain("fill_queue");
  endtask

  task automatic test_persist();
    bit acc;
    push_cmd(3'd6, 6'd0, acc);
    push_cmd(3'd0, 6'd2, acc);
    idle(3);
    for (int p = 1; p <= 4; p++) begin
      frame_pulse(6, "persist");
      n_cmp++;
      if ((p == 1 && flags !== 7'b1000000) || (p == 2 && flags !== 7'b1000001) ||
          (p == 4 && flags !== 7'b1000000)) begin
        n_fail++;
        $display("FAIL persist_seq pulse %0d: got %b", p, flags);
      end
    end
    push_cmd(3'd6, 6'd0, acc);
    drain("persist_again");
    n_cmp++;
    if (flags !== 7'b1000000) begin
      n_fail++;
      $display("FAIL persist_hold: got %b required 1000000", flags);
    end
  endtask

  task automatic test_clear_mid_show();
    bit acc;
    int d0;
    do_clear();
    push_cmd(3'd1, 6'd5, acc);
    frame_pulse(4, "clr_show");
    push_cmd(3'd2, 6'd1, acc);
    push_cmd(3'd3, 6'd1, acc);
    d0 = done_seen;
    do_clear();
    for (int p = 0; p < 2; p++) frame_pulse(6, "clr_after");
    n_cmp++;
    if (done_seen !== d0 || flags !== 7'd0) begin
      n_fail++;
      $display("FAIL clr_quiet: done_count=%0d flags=%b required %0d/0000000", done_seen, flags, d0);
    end
  endtask

  task automatic test_reset_show_invalid();
    bit acc;
    int d0;
    push_cmd(3'd3, 6'd4, acc);
    frame_pulse(4, "rst_show");
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (flags !== 7'd0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: flags=%b busy=%b done=%b required 0000000/0/0", flags, busy, done);
    end
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    d0 = done_seen;
    push_cmd(3'd7, 6'd3, acc);
    frame_pulse(4, "invalid");
    n_cmp++;
    if (done_seen !== d0 || flags !== 7'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid: done_count=%0d flags=%b busy=%b required %0d/0000000/0",
               done_seen, flags, busy, d0);
    end
  endtask

  task automatic test_clear_vs_frame();
    bit acc;
    push_cmd(3'd2, 6'd2, acc);
    idle(3);
    @(negedge clk);
    cmd_clear   = 1'b1;
    frame_start = 1'b1;
    @(negedge clk);
    cmd_clear   = 1'b0;
    frame_start = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if (flags !== 7'd0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_vs_frame: flags=%b busy=%b ready=%b required 0000000/0/1",
               flags, busy, cmd_ready);
    end
    frame_pulse(4, "clear_vs_frame_after");
  endtask

  task automatic test_random();
    bit acc;
    int npush;
    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 24) == 0) do_clear();
      npush = $urandom_range(0, 2);
      for (int j = 0; j < npush; j++) begin
        if (cmd_ready) push_cmd(3'($urandom_range(0, 7)), 6'($urandom_range(0, 3)), acc);
      end
      frame_pulse(14, "random");
    end
    drain("random_drain");
  endtask

  initial begin
    test_reset();
    test_red_timed();
    test_fill_queue();
    test_persist();
    test_clear_mid_show();
    test_reset_show_invalid();
    test_clear_vs_frame();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_sequencer.md
SPRITE_SEQUENCER -- requirements
Module: sprite_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command queue depth (power of two, min 2).
REQ-002 SHALL have parameter GAP_FRAMES, default 8, all-off frames between consecutive timed lights.
REQ-003 SHALL have port VGA_CLK  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port FRAME_START  input  1  one-cycle pulse per frame from the VGA timing at vertical-blank start.
REQ-006 SHALL have port CMD_VALID  input  1  command offered.
REQ-007 SHALL have port CMD_READY  output  1  command accepted when CMD_VALID and CMD_READY are both high.
REQ-008 SHALL have port CMD_SPRITE  input  3  sprite index: 0 blue, 1 green, 2 red, 3 yellow, 4 lose, 5 win, 6 power; 7 invalid.
REQ-009 SHALL have port CMD_FRAMES  input  6  on-time in frames; 0 = persistent (stays on until clear).
REQ-010 SHALL have port CMD_CLEAR  input  1  one-cycle pulse: flush queue, drop all flags.
REQ-011 SHALL have port SPRITES_FLAGS  output  7  per-sprite display enables to the VGA controller, bit = sprite index.
REQ-012 SHALL have port BUSY  output  1  high while queue non-empty or state not IDLE.
REQ-013 SHALL have port DONE  output  1  one-cycle pulse when a timed light ends.

Function
REQ-014 SHALL: CMD_READY = queue not full and CMD_CLEAR low; push of {sprite, frames} on handshake.
REQ-015 SHALL: simultaneous push and pop on a non-full queue leave the occupancy unchanged, order preserved.
REQ-016 SHALL implement FSM states IDLE, ARM, SHOW, GAP; state register and SPRITES_FLAGS registered.
REQ-017 SHALL: IDLE with queue non-empty pops one entry and enters ARM next cycle.
REQ-018 SHALL: ARM waits for FRAME_START; on it, frames>0 sets show bit, loads frame counter = frames, enters SHOW; frames=0 sets persistent bit, enters IDLE.
REQ-019 SHALL: popped sprite 7 is discarded in ARM on the next cycle, no flag, no DONE; return to IDLE.
REQ-020 SHALL: SHOW decrements counter per FRAME_START; on reaching 0, show bit clears, DONE pulses that same cycle, counter loads GAP_FRAMES, enter GAP (GAP_FRAMES=0 -> IDLE directly).
REQ-021 SHALL: GAP decrements per FRAME_START; at 0 enter IDLE.
REQ-022 SHALL: SPRITES_FLAGS = persistent bits OR one-hot show bit; changes only on the cycle after FRAME_START or CMD_CLEAR.
REQ-023 SHALL: a sprite lit for N frames stays on for exactly N FRAME_START intervals.
REQ-024 SHALL: CMD_CLEAR, in any state, empties the queue, zeroes persistent and show bits, zeroes the counter, enters IDLE, no DONE; it wins over a same-cycle FRAME_START or push.
REQ-025 SHALL: FRAME_START in IDLE with empty queue causes no change.
REQ-026 SHALL: persistent command for an already-lit sprite leaves the flag set, no error.

Reset
REQ-027 SHALL on RESET: state IDLE, queue empty, counter 0, SPRITES_FLAGS 0, DONE 0, BUSY 0, CMD_READY 1 after release.
REQ-028 SHALL: reset mid-SHOW drops lit flag immediately (asynchronously), no DONE.

Structure
REQ-029 SHALL place sprite index constants, state encoding and frame-count width (6) in shared package genius_pkg.
REQ-030 SHALL instantiate one sub-module sprite_cmd_fifo (synchronous FIFO, 9-bit entries, full/empty, flush input).
REQ-031 SHALL be 120-400 lines RTL total, no latches, no derived clocks.

Verification
REQ-032 SHALL test: push {red=2, frames=3}, FRAME_START every 100 cycles -> SPRITES_FLAGS=7'b0000100 after 1st pulse, 0 after 4th, DONE once.
REQ-033 SHALL test: push 4 commands with FIFO_DEPTH=4 while ARM -> 4th accepted, CMD_READY low while queue full, lights in order with 8-frame gaps.
REQ-034 SHALL test: push {power=6, frames=0} then {blue=0, frames=2} -> flags 7'b1000000 then 7'b1000001 then 7'b1000000, power held.
REQ-035 SHALL test: CMD_CLEAR mid-SHOW with 2 queued -> flags 0 next cycle, BUSY 0, no DONE, later FRAME_START no change.
REQ-036 SHALL test: assert RESET during SHOW -> flags 0 at once, BUSY 0; CMD_SPRITE=7 push -> no flag, no DONE, returns IDLE.
REQ-037 SHALL test: CMD_CLEAR and FRAME_START same cycle in ARM -> no flag set, queue empty.
